bfloat_mul_seq: RTL
===================

// Module: bfloat_mul_seq
// PURPOSE
//  Sequential BFloat16 multiplier; the companion to the BFloat16 divider in this unit library.
//  It accepts two bfloat16 operands through a valid/ready handshake.
//  The 8x8 significand product is formed by iterative shift-add, then normalised,
//  rounded to nearest-even and packed.
//  It sits beside the divider in the arithmetic unit and shares its special-value rules.
// PARAMETERS
//  BITS_PER_CYCLE  1  multiplier bits retired per MUL cycle; legal 1,2,4,8; N_MUL = 8/BITS_PER_CYCLE
// PORTS
//  clk        in   1   single clock; all state updates on posedge clk
//  rst        in   1   reset, synchronous, active-high
//  in_valid   in   1   operand pair a,b is valid
//  in_ready   out  1   block can accept operands (high only in IDLE)
//  a          in   16  bfloat16 multiplicand {sign,exp[7:0],frac[6:0]}
//  b          in   16  bfloat16 multiplier
//  out_valid  out  1   c and flags are valid; held until out_ready
//  out_ready  in   1   consumer accepts the result
//  c          out  16  bfloat16 product
//  ovf        out  1   result overflowed to +/-inf (valid with out_valid)
//  unf        out  1   result underflowed, flushed to signed zero
//  inv        out  1   invalid operation; c = canonical qNaN 16'h7FC0
// BEHAVIOUR
//  Reset: state=IDLE; in_ready=1; out_valid=0; c=16'h0000; ovf=unf=inv=0. Reset wins over all other events.
//  Reset mid-operation drops the operation; no out_valid is produced for it.
//  FSM: IDLE -> (in_valid&&in_ready) -> MUL (N_MUL cycles) -> NORM (1 cycle) -> DONE.
//   On acceptance, any special case skips MUL and NORM and goes IDLE->DONE directly.
//   DONE -> (out_ready) -> IDLE. in_ready=0 outside IDLE, so there is no overlap between operations.
//  Latency (acceptance edge to out_valid high): normal case N_MUL+2 cycles (10 when BITS_PER_CYCLE=1).
//   Special case: 1 cycle.
//  Backpressure: while out_valid && !out_ready, c, ovf, unf and inv are held stable. in_valid is ignored outside IDLE.
//  Operand classes:
//   - zero: exp==0; subnormals (exp==0, frac!=0) are flushed to zero on input.
//   - inf: exp==FF, frac==0.
//   - NaN: exp==FF, frac!=0.
//  Special cases, checked in this order:
//   1. Any NaN, or inf*zero -> c=7FC0, inv=1.
//   2. inf*x -> {sa^sb, FF, 0}.
//   3. zero*x -> {sa^sb, 00, 0}.
//  Normal datapath:
//   - ma={1,a[6:0]}, mb={1,b[6:0]}; p = ma*mb, 16 bits, built by shift-add in MUL.
//   - e = ea + eb - 127, carried as a 10-bit signed value.
//   - If p[15]: frac=p[14:8], guard=p[7], sticky=|p[6:0], e=e+1.
//     Else: frac=p[13:7], guard=p[6], sticky=|p[5:0].
//   - RNE: increment frac if guard && (sticky || frac[0]). A carry out of frac gives frac=0, e=e+1.
//   - e >= 255 -> c={s,FF,0}, ovf=1.
//   - e <= 0 -> c={s,00,0}, unf=1.
//   - Otherwise c={s, e[7:0], frac}.
//  Sign is always sa^sb, including for zero and inf results. The qNaN result is always positive 7FC0.
//  Flags are mutually exclusive and cleared when the next operation is accepted.
// STRUCTURE
//  Package bfloat_pkg holds:
//   - typedef struct packed {logic s; logic [7:0] e; logic [6:0] f;} bf16_t
//   - BF16_BIAS=127, BF16_EXP_MAX=8'hFF, BF16_QNAN=16'h7FC0
//   - function bf16_class() returning enum {ZERO,NORM,INF,NAN}
//   - the FSM state enum
//  One sub-module, bf16_round_pack: combinational; takes p, e and s and returns c, ovf and unf.
//   It is reusable by the divider.
//  The FSM, operand registers and shift-add accumulator live in bfloat_mul_seq.
// TESTING
//  1. a=4000 (2.0), b=4040 (3.0) -> c=40C0, flags 0, out_valid exactly 10 cycles after acceptance.
//  2. a=3FC1, b=3FC1 (p=9181, guard=1, sticky=1) -> c=4012 (round-up path).
//     Also a=BF80, b=4040 -> c=C040.
//  3. a=7F00, b=7F00 -> c=7F80, ovf=1. a=0080, b=0080 -> c=0000, unf=1.
//  4. a=7F80, b=0000 -> c=7FC0, inv=1, latency 1.
//     a=FF80, b=4000 -> c=FF80. a=8000, b=4000 -> c=8000.
//  5. Hold out_ready=0 for 5 cycles after out_valid -> c and flags stable, in_ready=0.
//     Then out_ready=1 -> next cycle in_ready=1. A back-to-back stream of 20 random pairs matches the golden model.
//  6. Assert rst during MUL -> next cycle state IDLE, out_valid=0, c=0000.
//     No stale result appears; the following operation completes correctly.

Source files
------------

// File: rtl/bfloat_mul_seq_pkg.sv
// Shared bfloat16 types, constants and the operand classifier used by the
// multiplier (and by the divider that sits next to it in the unit).
package bfloat_pkg;

  typedef struct packed {
    logic       s;
    logic [7:0] e;
    logic [6:0] f;
  } bf16_t;

  localparam int          BF16_BIAS    = 127;
  localparam logic [7:0]  BF16_EXP_MAX = 8'hFF;
  localparam logic [15:0] BF16_QNAN    = 16'h7FC0;

  // Operand class; subnormals fall into ZERO because they are flushed on input.
  typedef enum logic [1:0] {ZERO, NORM, INF, NAN} bf16_class_e;

  // Multiplier sequencer states.
  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_NORM, ST_DONE} mul_state_e;

  function automatic bf16_class_e bf16_class(input bf16_t x);
    bf16_class_e cls;
    if (x.e == 8'h00) begin
      cls = ZERO;
    end else if (x.e == BF16_EXP_MAX) begin
      if (x.f == 7'd0) cls = INF;
      else             cls = NAN;
    end else begin
      cls = NORM;
    end
    return cls;
  endfunction

endpackage

// File: rtl/bfloat_mul_seq_if.sv
// Operand/result handshake bundle for the bfloat16 multiplier.
interface bfloat_mul_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] c;
  logic        ovf;
  logic        unf;
  logic        inv;

  // Master issues operands and consumes results.
  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, c, ovf, unf, inv
  );

  // Slave is the arithmetic unit.
  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, c, ovf, unf, inv
  );
endinterface

// File: rtl/bfloat_mul_seq_round_pack.sv
// Normalise a 16-bit significand product, round to nearest-even and pack
// into bfloat16 with overflow/underflow saturation. Purely combinational so
// the divider can reuse it on its own quotient.
module bf16_round_pack
  import bfloat_pkg::*;
(
  input  logic [15:0]       p,
  input  logic signed [9:0] e,
  input  logic              s,
  output logic [15:0]       c,
  output logic              ovf,
  output logic              unf
);

  logic signed [9:0] e_norm;
  logic signed [9:0] e_fin;
  logic [6:0]        frac;
  logic              guard;
  logic              sticky;
  logic              round_up;
  logic [7:0]        frac_rnd;

  // Pick the leading one (bit 15 or 14), round, then range-check the exponent.
  always_comb begin
    if (p[15]) begin
      frac   = p[14:8];
      guard  = p[7];
      sticky = |p[6:0];
      e_norm = e + 10'sd1;
    end else begin
      frac   = p[13:7];
      guard  = p[6];
      sticky = |p[5:0];
      e_norm = e;
    end

    round_up = guard & (sticky | frac[0]);
    frac_rnd = {1'b0, frac} + {7'd0, round_up};
    // A carry out of the fraction leaves frac_rnd[6:0]==0 and bumps the exponent.
    e_fin    = frac_rnd[7] ? (e_norm + 10'sd1) : e_norm;

    ovf = 1'b0;
    unf = 1'b0;
    if (e_fin >= 10'sd255) begin
      c   = {s, BF16_EXP_MAX, 7'd0};
      ovf = 1'b1;
    end else if (e_fin <= 10'sd0) begin
      c   = {s, 8'h00, 7'd0};
      unf = 1'b1;
    end else begin
      c   = {s, e_fin[7:0], frac_rnd[6:0]};
    end
  end

endmodule

// File: rtl/bfloat_mul_seq.sv
// Sequential bfloat16 multiplier: shift-add significand product over N_MUL
// cycles, one normalise/round cycle, result held until the consumer takes it.
// Special operands are resolved at acceptance and bypass the datapath.
module bfloat_mul_seq
  import bfloat_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic clk,
  input  logic rst,
  bfloat_mul_seq_if.slave bus
);

  localparam int N_MUL = 8 / BITS_PER_CYCLE;
  localparam int CW    = (N_MUL > 1) ? $clog2(N_MUL) : 1;

  mul_state_e        state_q;
  logic              in_ready_q;
  logic              out_valid_q;
  logic [15:0]       c_q;
  logic              ovf_q;
  logic              unf_q;
  logic              inv_q;
  logic [15:0]       ma_q;
  logic [7:0]        mb_q;
  logic [15:0]       acc_q;
  logic signed [9:0] exp_q;
  logic              sign_q;
  logic [CW-1:0]     cnt_q;

  bf16_t             op_a;
  bf16_t             op_b;
  bf16_class_e       cls_a;
  bf16_class_e       cls_b;
  logic              spec_hit;
  logic              spec_inv;
  logic [15:0]       spec_c;
  logic signed [9:0] exp_d;
  logic [15:0]       acc_d;
  logic [15:0]       pp_sum;
  logic [15:0]       pp [BITS_PER_CYCLE];

  logic [15:0]       rp_c;
  logic              rp_ovf;
  logic              rp_unf;

  assign op_a  = bus.a;
  assign op_b  = bus.b;
  assign cls_a = bf16_class(op_a);
  assign cls_b = bf16_class(op_b);

  // Biased exponent sum; 10-bit two's complement holds -125..381 plus rounding bumps.
  assign exp_d = $signed({2'b00, op_a.e} + {2'b00, op_b.e} - 10'(BF16_BIAS));

  // Special-value resolution in priority order: invalid, infinity, zero.
  always_comb begin
    spec_hit = 1'b1;
    spec_inv = 1'b0;
    spec_c   = 16'h0000;
    if (cls_a == NAN || cls_b == NAN ||
        (cls_a == INF && cls_b == ZERO) || (cls_a == ZERO && cls_b == INF)) begin
      spec_c   = BF16_QNAN;
      spec_inv = 1'b1;
    end else if (cls_a == INF || cls_b == INF) begin
      spec_c   = {op_a.s ^ op_b.s, BF16_EXP_MAX, 7'd0};
    end else if (cls_a == ZERO || cls_b == ZERO) begin
      spec_c   = {op_a.s ^ op_b.s, 8'h00, 7'd0};
    end else begin
      spec_hit = 1'b0;
    end
  end

  // One partial product per multiplier bit retired this cycle.
  for (genvar gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_pp
    assign pp[gi] = mb_q[gi] ? (ma_q << gi) : 16'd0;
  end

  // Sum this cycle's partial products into the running accumulator.
  always_comb begin
    pp_sum = 16'd0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      pp_sum = pp_sum + pp[i];
    end
    acc_d = acc_q + pp_sum;
  end

  bf16_round_pack u_round_pack (
    .p   (acc_q),
    .e   (exp_q),
    .s   (sign_q),
    .c   (rp_c),
    .ovf (rp_ovf),
    .unf (rp_unf)
  );

  // Sequencer with registered handshake and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      c_q         <= 16'h0000;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      inv_q       <= 1'b0;
      ma_q        <= 16'd0;
      mb_q        <= 8'd0;
      acc_q       <= 16'd0;
      exp_q       <= 10'sd0;
      sign_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            in_ready_q <= 1'b0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            inv_q      <= 1'b0;
            sign_q     <= op_a.s ^ op_b.s;
            if (spec_hit) begin
              c_q         <= spec_c;
              inv_q       <= spec_inv;
              out_valid_q <= 1'b1;
              state_q     <= ST_DONE;
            end else begin
              ma_q    <= {8'd0, 1'b1, op_a.f};
              mb_q    <= {1'b1, op_b.f};
              acc_q   <= 16'd0;
              exp_q   <= exp_d;
              cnt_q   <= CW'(N_MUL - 1);
              state_q <= ST_MUL;
            end
          end
        end
        ST_MUL: begin
          acc_q <= acc_d;
          ma_q  <= ma_q << BITS_PER_CYCLE;
          mb_q  <= mb_q >> BITS_PER_CYCLE;
          if (cnt_q == '0) state_q <= ST_NORM;
          else             cnt_q   <= cnt_q - 1'b1;
        end
        ST_NORM: begin
          c_q         <= rp_c;
          ovf_q       <= rp_ovf;
          unf_q       <= rp_unf;
          out_valid_q <= 1'b1;
          state_q     <= ST_DONE;
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.c         = c_q;
  assign bus.ovf       = ovf_q;
  assign bus.unf       = unf_q;
  assign bus.inv       = inv_q;

endmodule
